// File: rtl/tx_sched.sv
// Round-robin scheduler feeding a hex-to-char converter into a UART TX, four bytes per request, MSB first.
// Optional build macro TX_SCHED_ZSKIP_EN: converter bytes equal to 8'h00 are skipped instead of sent.
module tx_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_data,
   input  logic        req1_mode,
   output logic        req1_ready,
   output logic [31:0] all,
   output logic        type_tx,
   output logic        data_mode,
   output logic [3:0]  cnt,
   input  logic [7:0]  dout,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

   state_t     state;
   logic       rr_last;    // 1 when req1 holds the most recent grant
   logic [7:0] tx_data_q;
   logic       skip;
   logic       step;

`ifdef TX_SCHED_ZSKIP_EN
   assign skip = (dout == 8'h00);
`else
   assign skip = 1'b0;
`endif

   assign req0_ready = (state == IDLE) && req0_valid && (!req1_valid || rr_last);
   assign req1_ready = (state == IDLE) && req1_valid && (!req0_valid || !rr_last);

   // Strobe is decoded from SEND so it coincides with the byte on dout and never shows outside SEND.
   assign tx_start = (state == SEND) && !skip && !tx_busy;
   assign tx_data  = tx_start ? dout : tx_data_q;

   assign step = ((state == SEND) && skip) || ((state == WAIT_LO) && !tx_busy);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         all       <= 32'd0;
         type_tx   <= 1'b0;
         data_mode <= 1'b0;
         tx_data_q <= 8'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rr_last   <= 1'b1;
      end else begin
         done <= 1'b0;
         if (step) begin
            if (cnt > 4'd1) begin
               cnt   <= cnt - 4'd1;
               state <= SEND;
            end else begin
               cnt   <= 4'd0;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (req0_ready) begin
                     all       <= req0_data;
                     type_tx   <= 1'b0;
                     data_mode <= 1'b1;
                     rr_last   <= 1'b0;
                     cnt       <= 4'd4;
                     busy      <= 1'b1;
                     state     <= SEND;
                  end else if (req1_ready) begin
                     all       <= req1_data;
                     type_tx   <= 1'b1;
                     data_mode <= req1_mode;
                     rr_last   <= 1'b1;
                     cnt       <= 4'd4;
                     busy      <= 1'b1;
                     state     <= SEND;
                  end
               end
               SEND: begin
                  if (!tx_busy) begin
                     tx_data_q <= dout;
                     state     <= WAIT_HI;
                  end
               end
               WAIT_HI: begin
                  if (tx_busy) state <= WAIT_LO;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tx_sched.sv
// Scoreboard bench for tx_sched: stimulus pushes expected bytes/done markers, a monitor pops on tx_start/done.
module tb_tx_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, req1_mode;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic [31:0] all;
   logic        type_tx, data_mode;
   logic [3:0]  cnt;
   logic [7:0]  dout;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        busy, done;

   logic [31:0] conv_word;
   int          busy_len;
   int          tests, fails, overlap;
   int          exp_q[$];
   int          grants[$];

   localparam int DONE_MARK = 256;

   always #5 clk = ~clk;

   tx_sched dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_mode(req1_mode), .req1_ready(req1_ready),
      .all(all), .type_tx(type_tx), .data_mode(data_mode), .cnt(cnt), .dout(dout),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .busy(busy), .done(done)
   );

   // Converter model: response passthrough mode returns the raw word, other modes a per-test table word.
   always_comb begin
      logic [31:0] w;
      w    = (type_tx && !data_mode) ? all : conv_word;
      dout = 8'h00;
      case (cnt)
         4'd4: dout = w[31:24];
         4'd3: dout = w[23:16];
         4'd2: dout = w[15:8];
         4'd1: dout = w[7:0];
         default: dout = 8'h00;
      endcase
   end

   // UART model: busy rises the cycle after a strobe and stays up busy_len cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic push_seq(input logic [31:0] w);
      logic [7:0] b;
      for (int i = 3; i >= 0; i--) begin
         b = w[8*i +: 8];
`ifdef TX_SCHED_ZSKIP_EN
         if (b != 8'h00) exp_q.push_back(int'(b));
`else
         exp_q.push_back(int'(b));
`endif
      end
      exp_q.push_back(DONE_MARK);
   endtask

   task automatic monitor();
      int e;
      forever begin
         @(negedge clk);
         if (req0_ready === 1'b1 && req1_ready === 1'b1) overlap++;
         if (req0_valid && req0_ready === 1'b1) grants.push_back(0);
         if (req1_valid && req1_ready === 1'b1) grants.push_back(1);
         if (tx_start === 1'b1) begin
            chk("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_tx_start: got data %h expected no strobe", tx_data);
            end else begin
               e = exp_q.pop_front();
               chk("tx_data", {24'd0, tx_data}, e);
            end
         end
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_done: got done=1 expected no pulse");
            end else begin
               e = exp_q.pop_front();
               chk("done_order", e, DONE_MARK);
            end
         end
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk); #1;
         n++;
      end
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   // Issue one request, wait for its accept, then check the latched context.
   task automatic issue(input int which, input logic [31:0] data, input logic mode, input logic [31:0] conv);
      int n = 0;
      conv_word = conv;
      push_seq((which == 1 && !mode) ? data : conv);
      @(posedge clk); #1;
      if (which == 0) begin req0_data = data; req0_valid = 1'b1; end
      else begin req1_data = data; req1_mode = mode; req1_valid = 1'b1; end
      do begin
         @(negedge clk); #1;
         n++;
      end while (!((which == 0) ? req0_ready : req1_ready) && n < 100);
      chk("accept_timeout", (n < 100) ? 32'd1 : 32'd0, 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      chk("latched_all", all, data);
      chk("latched_type", {31'd0, type_tx}, (which == 1) ? 32'd1 : 32'd0);
      chk("latched_mode", {31'd0, data_mode}, (which == 1) ? {31'd0, mode} : 32'd1);
      chk("busy_in_seq", {31'd0, busy}, 32'd1);
      chk("cnt_start", {28'd0, cnt}, 32'd4);
   endtask

   initial begin
      int n;
      tests = 0; fails = 0; overlap = 0;
      busy_len = 3;
      conv_word = 32'd0;
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; req1_mode = 1'b0;
      req0_data = 32'd0; req1_data = 32'd0;
      fork monitor(); join_none
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cnt", {28'd0, cnt}, 32'd0);
      chk("rst_all", all, 32'd0);
      chk("rst_type", {31'd0, type_tx}, 32'd0);
      chk("rst_mode", {31'd0, data_mode}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);

      // Echo: 0x0D0A line ending with leading zero bytes.
      issue(0, 32'h000000FF, 1'b1, 32'h00000D0A);
      wait_drain();
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_cnt", {28'd0, cnt}, 32'd0);
      chk("held_all", all, 32'h000000FF);

      // Response, converted mode.
      issue(1, 32'h0500003A, 1'b1, 32'h00443341);
      wait_drain();

      // Response, raw mode with an embedded zero byte.
      issue(1, 32'h41420043, 1'b0, 32'h0);
      wait_drain();
      chk("held_type", {31'd0, type_tx}, 32'd1);

      // Long UART busy: no strobe may appear while tx_busy is high.
      busy_len = 100;
      issue(0, 32'h12345678, 1'b1, 32'h31323334);
      wait_drain();

      // Reset while waiting for busy to fall: abort, no done, no re-send.
      busy_len = 20;
      issue(1, 32'h41424344, 1'b0, 32'h0);
      n = 0;
      while (exp_q.size() > 4 && n < 200) begin @(negedge clk); #1; n++; end
      chk("first_strobe_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
      repeat (5) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_cnt", {28'd0, cnt}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_all", all, 32'd0);
      repeat (40) @(negedge clk);

      // Round-robin with both requesters held valid.
      busy_len = 3;
      grants.delete();
      conv_word = 32'h31323334;
      push_seq(32'h31323334);
      push_seq(32'h41424344);
      push_seq(32'h31323334);
      push_seq(32'h41424344);
      @(posedge clk); #1;
      req0_data = 32'h00000011; req1_data = 32'h41424344; req1_mode = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      n = 0;
      while (grants.size() < 4 && n < 3000) begin @(negedge clk); #1; n++; end
      chk("rr_grant_timeout", grants.size(), 4);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_drain();
      for (int i = 0; i < 4; i++)
         chk("rr_grant_order", (i < grants.size()) ? grants[i] : -1, i % 2);
      chk("ready_overlap", overlap, 0);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tx_sched.md
TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: req0_valid  in  1  echo requester has a byte to send; req0_data  in  32  echo word (low byte significant).
REQ-004 SHALL have ports: req0_ready  out  1  echo request accepted this cycle.
REQ-005 SHALL have ports: req1_valid  in  1  response requester has a word; req1_data  in  32  response word; req1_mode  in  1  data_mode for response.
REQ-006 SHALL have ports: req1_ready  out  1  response request accepted this cycle.
REQ-007 SHALL have ports: all  out  32, type_tx  out  1, data_mode  out  1, cnt  out  4  drive the hex-to-char converter; dout  in  8  converter byte for current cnt.
REQ-008 SHALL have ports: tx_start  out  1  one-cycle send strobe to UART TX; tx_data  out  8  byte to send; tx_busy  in  1  UART TX busy.
REQ-009 SHALL have ports: busy  out  1  sequence in progress; done  out  1  one-cycle pulse, sequence finished.

Function
REQ-010 SHALL implement states IDLE, SEND, WAIT_HI, WAIT_LO.
REQ-011 In IDLE, busy=0 and cnt=0; a request is accepted when valid and ready are both high on the same edge.
REQ-012 Arbitration SHALL occur only in IDLE: a single valid requester wins; when both are valid, the requester not granted last wins (round-robin).
REQ-013 reqN_ready SHALL be combinational: high only in IDLE for the requester that wins arbitration; never both high.
REQ-014 On accept: latch all=reqN_data; req0 sets type_tx=0, data_mode=1; req1 sets type_tx=1, data_mode=req1_mode; set cnt=4; go to SEND. all/type_tx/data_mode SHALL hold until the next accept.
REQ-015 In SEND, if the byte is to be skipped (REQ-024), SHALL step cnt without sending, one cycle per skipped byte.
REQ-016 In SEND, if the byte is not skipped and tx_busy=0, SHALL assert tx_start for exactly one cycle with tx_data=dout, then go to WAIT_HI; if tx_busy=1, SHALL stall in SEND.
REQ-017 WAIT_HI SHALL wait for tx_busy=1, then go to WAIT_LO; WAIT_LO SHALL wait for tx_busy=0.
REQ-018 On leaving WAIT_LO, or on a skip: if cnt>1, SHALL decrement cnt and go to SEND; if cnt=1, SHALL pulse done, set cnt=0, and go to IDLE.
REQ-019 Bytes SHALL be sent MSB-first: cnt 4,3,2,1 in that order.
REQ-020 Earliest first tx_start: the cycle after accept. A new accept is possible the cycle after done.
REQ-021 tx_data SHALL hold its last value between strobes; tx_start SHALL never be high in IDLE, WAIT_HI or WAIT_LO.

Reset
REQ-022 When rst=1, the block SHALL on that edge: go to IDLE; set cnt=0, all=0, type_tx=0, data_mode=0, tx_data=0, tx_start=0, busy=0, done=0; set the round-robin pointer so req0 wins the first tie.
REQ-023 Reset mid-sequence SHALL abort it with no further tx_start and no done; the aborted request SHALL NOT be re-sent.

Configuration
REQ-024 Macro TX_SCHED_ZSKIP_EN: when defined, a byte with dout==8'h00 SHALL be skipped in every mode; when undefined, all four bytes SHALL be sent, including 8'h00 bytes.

Verification
REQ-025 With ZSKIP: req0_data=32'h000000FF -> converter word 32'h00000D0A -> tx_data 8'h0D then 8'h0A, then one done pulse.
REQ-026 With ZSKIP: req1_data=32'h0500003A, req1_mode=1 -> bytes 8'h44, 8'h33, 8'h41.
REQ-027 req1_mode=0, req1_data=32'h41420043 -> without macro: 41,42,00,43; with macro: 41,42,43.
REQ-028 After reset, req0 and req1 held valid continuously -> grants in the order req0, req1, req0, req1; req0_ready and req1_ready are never high together.
REQ-029 tx_busy held high for 100 cycles after a strobe -> no further tx_start until tx_busy falls; rst pulsed in WAIT_LO -> next cycle IDLE, cnt=0, busy=0, no done.
